counter_nb: RTL and testbench

- Parametrised successor of the team's 4-bit mode counter.
- N-bit synchronous up/down/step counter with parallel load and mode select.
- Adds a working ripple-carry output (RCO) that flags wrap-around, plus a programmable step mode.
- Used as a cascadable timer/counter primitive in the synthesis flow. Outputs drive Q, RCO and LOAD through registers.

---
 rtl/counter_nb.sv | 82 ++++++++
 tb/tb_counter_nb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_nb.sv
// Parametrised up/down/step counter with parallel load, registered wrap flag (RCO)
// and registered load acknowledge (LOAD); cascadable by wiring RCO to the next ENABLE.
module counter_nb #(
   parameter int          WIDTH = 4,
   parameter int unsigned STEP  = 3
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             LOAD
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_STEP = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("counter_nb: WIDTH must be in 2..32");
   end

   if (STEP < 1 || longint'(STEP) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
      $error("counter_nb: STEP must be in 1..2^WIDTH-1");
   end

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] next_q;
   logic             next_rco;
   logic             next_load;

   // Up modes add in WIDTH+1 bits so the top bit is the wrap flag.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      sum       = '0;
      next_q    = Q;
      next_rco  = 1'b0;
      next_load = 1'b0;
      if (ENABLE) begin
         unique case (mode_e'(MODO))
            MODE_UP: begin
               sum      = {1'b0, Q} + (WIDTH+1)'(1);
               next_q   = sum[WIDTH-1:0];
               next_rco = sum[WIDTH];
            end
            MODE_DOWN: begin
               next_q   = Q - WIDTH'(1);
               next_rco = (Q == '0);
            end
            MODE_STEP: begin
               sum      = {1'b0, Q} + (WIDTH+1)'(STEP);
               next_q   = sum[WIDTH-1:0];
               next_rco = sum[WIDTH];
            end
            MODE_LOAD: begin
               next_q    = D;
               next_load = 1'b1;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments and the async reset clears
   // every output flop, so no pulse survives reset.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         Q    <= '0;
         RCO  <= 1'b0;
         LOAD <= 1'b0;
      end else begin
         Q    <= next_q;
         RCO  <= next_rco;
         LOAD <= next_load;
      end
   end

endmodule

// File: tb/tb_counter_nb.sv
// Self-checking bench for counter_nb: directed wrap/borrow/step/load/cascade cases
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_counter_nb;

   logic clk = 1'b0;
   logic RESET;
   always #5 clk = ~clk;

   // Instance A: WIDTH=4 STEP=3; instance B: WIDTH=8 STEP=5; C0/C1: cascaded WIDTH=4.
   logic       en_a, en_b, en_c;
   logic [1:0] modo_a, modo_b;
   logic [3:0] d_a;
   logic [7:0] d_b;
   logic [3:0] q_a, q_c0, q_c1;
   logic [7:0] q_b;
   logic       rco_a, rco_b, rco_c0, rco_c1;
   logic       load_a, load_b, load_c0, load_c1;
   logic [1:0] modo_c = 2'b00;
   logic [3:0] d_c    = 4'h0;

   counter_nb #(.WIDTH(4), .STEP(3)) dut_a (
      .clk(clk), .RESET(RESET), .ENABLE(en_a), .MODO(modo_a), .D(d_a),
      .Q(q_a), .RCO(rco_a), .LOAD(load_a));

   counter_nb #(.WIDTH(8), .STEP(5)) dut_b (
      .clk(clk), .RESET(RESET), .ENABLE(en_b), .MODO(modo_b), .D(d_b),
      .Q(q_b), .RCO(rco_b), .LOAD(load_b));

   counter_nb #(.WIDTH(4), .STEP(3)) dut_c0 (
      .clk(clk), .RESET(RESET), .ENABLE(en_c), .MODO(modo_c), .D(d_c),
      .Q(q_c0), .RCO(rco_c0), .LOAD(load_c0));

   counter_nb #(.WIDTH(4), .STEP(3)) dut_c1 (
      .clk(clk), .RESET(RESET), .ENABLE(rco_c0), .MODO(modo_c), .D(d_c),
      .Q(q_c1), .RCO(rco_c1), .LOAD(load_c1));

   int n_checks = 0;
   int n_errors = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain modular arithmetic on integers, indexed A, B, C0, C1.
   longint mq[4];
   bit     mrco[4];
   bit     mload[4];

   task automatic model_next(input int width, input longint step, input longint q,
                             input bit en, input int modo, input longint d,
                             output longint nq, output bit nr, output bit nl);
      longint modulus = longint'(1) << width;
      longint t;
      nq = q; nr = 1'b0; nl = 1'b0;
      if (en) begin
         case (modo)
            0: begin t = q + 1;    nq = t % modulus; nr = (t >= modulus); end
            1: begin nr = (q == 0); nq = (q + modulus - 1) % modulus; end
            2: begin t = q + step; nq = t % modulus; nr = (t >= modulus); end
            default: begin nq = d; nl = 1'b1; end
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin mq[i] = 0; mrco[i] = 0; mload[i] = 0; end
   end

   always @(posedge clk or negedge RESET) begin
      longint nq[4];
      bit     nr[4];
      bit     nl[4];
      if (!RESET) begin
         for (int i = 0; i < 4; i++) begin mq[i] = 0; mrco[i] = 0; mload[i] = 0; end
      end else begin
         model_next(4, 3, mq[0], en_a, int'(modo_a), longint'(d_a), nq[0], nr[0], nl[0]);
         model_next(8, 5, mq[1], en_b, int'(modo_b), longint'(d_b), nq[1], nr[1], nl[1]);
         model_next(4, 3, mq[2], en_c, 0, 0, nq[2], nr[2], nl[2]);
         model_next(4, 3, mq[3], mrco[2], 0, 0, nq[3], nr[3], nl[3]);
         for (int i = 0; i < 4; i++) begin mq[i] = nq[i]; mrco[i] = nr[i]; mload[i] = nl[i]; end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("a_q", 64'(q_a), 64'(mq[0]));
         check("a_rco", 64'(rco_a), 64'(mrco[0]));
         check("a_load", 64'(load_a), 64'(mload[0]));
         check("b_q", 64'(q_b), 64'(mq[1]));
         check("b_rco", 64'(rco_b), 64'(mrco[1]));
         check("b_load", 64'(load_b), 64'(mload[1]));
         check("c0_q", 64'(q_c0), 64'(mq[2]));
         check("c0_rco", 64'(rco_c0), 64'(mrco[2]));
         check("c1_q", 64'(q_c1), 64'(mq[3]));
         check("c1_rco", 64'(rco_c1), 64'(mrco[3]));
         check("c_load", 64'({load_c0, load_c1}), 64'(0));
         check("a_pulse_excl", 64'(rco_a & load_a), 64'(0));
         check("b_pulse_excl", 64'(rco_b & load_b), 64'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      RESET = 1'b1;
      en_a = 0; en_b = 0; en_c = 0;
      modo_a = 0; modo_b = 0; d_a = 0; d_b = 0;
      #1 RESET = 1'b0;
      checking = 1'b1;
      #1;
      check("init_q_a", 64'(q_a), 0);
      check("init_load_a", 64'(load_a), 0);
      tick();
      tick();
      RESET = 1'b1;

      // Async reset while Q=9 with LOAD high.
      en_a = 1; modo_a = 2'b11; d_a = 4'd9;
      tick();
      check("load9_q", 64'(q_a), 9);
      check("load9_ack", 64'(load_a), 1);
      en_a = 0;
      #3 RESET = 1'b0;
      #1;
      check("async_rst_q", 64'(q_a), 0);
      check("async_rst_rco", 64'(rco_a), 0);
      check("async_rst_load", 64'(load_a), 0);
      tick();
      en_a = 1; modo_a = 2'b00;
      tick();
      check("rst_held_q", 64'(q_a), 0);
      RESET = 1'b1;
      tick();
      check("rst_release_q", 64'(q_a), 1);

      // Up wrap at WIDTH=4.
      modo_a = 2'b11; d_a = 4'd14;
      tick();
      modo_a = 2'b00;
      tick(); check("up_q15", 64'(q_a), 15); check("up_rco0", 64'(rco_a), 0);
      check("up_load_clr", 64'(load_a), 0);
      tick(); check("up_q0", 64'(q_a), 0);   check("up_rco1", 64'(rco_a), 1);
      tick(); check("up_q1", 64'(q_a), 1);   check("up_rco_end", 64'(rco_a), 0);

      // Step mode STEP=3.
      modo_a = 2'b11; d_a = 4'd12;
      tick();
      modo_a = 2'b10;
      tick(); check("step_q15", 64'(q_a), 15); check("step_rco_a", 64'(rco_a), 0);
      tick(); check("step_q2", 64'(q_a), 2);   check("step_rco_b", 64'(rco_a), 1);
      tick(); check("step_q5", 64'(q_a), 5);   check("step_rco_c", 64'(rco_a), 0);
      en_a = 0;

      // Down borrow at WIDTH=8.
      en_b = 1; modo_b = 2'b11; d_b = 8'd1;
      tick();
      modo_b = 2'b01;
      tick(); check("down_q0", 64'(q_b), 0);     check("down_rco0", 64'(rco_b), 0);
      tick(); check("down_q255", 64'(q_b), 255); check("down_rco1", 64'(rco_b), 1);
      tick(); check("down_q254", 64'(q_b), 254); check("down_rco_end", 64'(rco_b), 0);

      // Load, then hold with ENABLE=0.
      modo_b = 2'b11; d_b = 8'hA5;
      tick(); check("ld_a5_q", 64'(q_b), 165); check("ld_a5_ack", 64'(load_b), 1);
      check("ld_a5_rco", 64'(rco_b), 0);
      en_b = 0; modo_b = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_q", 64'(q_b), 165);
         check("hold_pulses", 64'({rco_b, load_b}), 0);
      end
      en_b = 1; modo_b = 2'b11; d_b = 8'hFF;
      tick(); check("ld_ff_ack", 64'(load_b), 1);
      modo_b = 2'b00;
      tick(); check("ff_wrap_q", 64'(q_b), 0); check("ff_wrap_rco", 64'(rco_b), 1);
      check("ff_wrap_load", 64'(load_b), 0);
      modo_b = 2'b11; d_b = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("b2b_load", 64'(load_b), 1);
      end
      en_b = 0;

      // Cascade: 50 clocks -> C0 wraps at edges 16/32/48, C1 steps at 17/33/49.
      en_c = 1;
      for (int i = 0; i < 50; i++) tick();
      check("casc_q0", 64'(q_c0), 2);
      check("casc_q1", 64'(q_c1), 3);
      en_c = 0;

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 600; i++) begin
         tick();
         en_a   = ($urandom_range(0, 7) != 0);
         en_b   = ($urandom_range(0, 7) != 0);
         en_c   = ($urandom_range(0, 3) != 0);
         modo_a = 2'($urandom_range(0, 3));
         modo_b = 2'($urandom_range(0, 3));
         d_a    = 4'($urandom);
         d_b    = 8'($urandom);
         if (!RESET) RESET = 1'b1;
         else if ($urandom_range(0, 59) == 0) begin
            #2 RESET = 1'b0;
         end
      end
      RESET = 1'b1;
      tick();
      tick();
      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
